operand_scoreboard: RTL

Register-file responder for the read-operands stage. It holds the 32×32 architectural register file and a per-register pending-write scoreboard, and forwards results from the EX, MEM and WB stages. It answers each read-operand request (`r1_addr`/`r2_addr`) in the same cycle with `rN_valid`/`rN_data`. It sits beside the read-operands stage: that stage drives addresses and issues destinations; the back-end pipeline drives forwarding and writeback.

---
 rtl/operand_scoreboard_if.sv | 52 +++++
 rtl/operand_scoreboard.sv | 120 ++++++++++++
 2 files changed

// File: rtl/operand_scoreboard_if.sv
// Bundle between the read-operands stage / back-end pipeline and the operand scoreboard.
// master drives addresses, issue and forwarding; slave answers operands and issue_block.
interface operand_scoreboard_if;
    logic        flush;

    logic [4:0]  r1_addr;
    logic        r1_valid;
    logic [31:0] r1_data;
    logic [4:0]  r2_addr;
    logic        r2_valid;
    logic [31:0] r2_data;

    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_block;

    logic        ex_fwd_valid;
    logic [4:0]  ex_fwd_dest;
    logic        ex_fwd_ready;
    logic [31:0] ex_fwd_data;

    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_dest;
    logic        mem_fwd_ready;
    logic [31:0] mem_fwd_data;

    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    modport master (
        output flush,
        output r1_addr, r2_addr,
        output issue_valid, issue_dest,
        output ex_fwd_valid, ex_fwd_dest, ex_fwd_ready, ex_fwd_data,
        output mem_fwd_valid, mem_fwd_dest, mem_fwd_ready, mem_fwd_data,
        output wb_valid, wb_dest, wb_data,
        input  r1_valid, r1_data, r2_valid, r2_data,
        input  issue_block
    );

    modport slave (
        input  flush,
        input  r1_addr, r2_addr,
        input  issue_valid, issue_dest,
        input  ex_fwd_valid, ex_fwd_dest, ex_fwd_ready, ex_fwd_data,
        input  mem_fwd_valid, mem_fwd_dest, mem_fwd_ready, mem_fwd_data,
        input  wb_valid, wb_dest, wb_data,
        output r1_valid, r1_data, r2_valid, r2_data,
        output issue_block
    );
endinterface

// File: rtl/operand_scoreboard.sv
// 32x32 register file with per-register pending-write counters and EX/MEM/WB forwarding.
// Two combinational read ports resolve youngest producer first.
module operand_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input logic                 clk,
    input logic                 resetn,
    operand_scoreboard_if.slave bus
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [31:0]      rf_q  [32];
    logic [31:0]      rf_d  [32];

    logic [31:0] issue_hit;
    logic [31:0] wb_hit;

    logic [4:0]  rd_addr  [2];
    logic        rd_valid [2];
    logic [31:0] rd_data  [2];

    // One-hot decode of the registers touched by issue and writeback this cycle.
    always_comb begin
        issue_hit = '0;
        wb_hit    = '0;
        if (bus.issue_valid && bus.issue_dest != 5'd0) begin
            issue_hit[bus.issue_dest] = 1'b1;
        end
        if (bus.wb_valid && bus.wb_dest != 5'd0) begin
            wb_hit[bus.wb_dest] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (i == 0 || bus.flush) begin
                cnt_d[i] = '0;
            end else if (issue_hit[i] && !wb_hit[i]) begin
                if (cnt_q[i] != CntMax) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (wb_hit[i] && !issue_hit[i]) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // Writeback commits even under flush; x0 stays hardwired to zero.
    always_comb begin
        rf_d = rf_q;
        if (bus.wb_valid && bus.wb_dest != 5'd0) begin
            rf_d[bus.wb_dest] = bus.wb_data;
        end
        rf_d[0] = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
                rf_q[i]  <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            rf_q  <= rf_d;
        end
    end

    assign rd_addr[0] = bus.r1_addr;
    assign rd_addr[1] = bus.r2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_valid[p] = 1'b0;
            rd_data[p]  = '0;
            if (rd_addr[p] == 5'd0) begin
                rd_valid[p] = 1'b1;
                rd_data[p]  = '0;
            end else if (bus.ex_fwd_valid && bus.ex_fwd_dest == rd_addr[p]) begin
                rd_valid[p] = bus.ex_fwd_ready;
                rd_data[p]  = bus.ex_fwd_data;
            end else if (bus.mem_fwd_valid && bus.mem_fwd_dest == rd_addr[p]) begin
                rd_valid[p] = bus.mem_fwd_ready;
                rd_data[p]  = bus.mem_fwd_data;
            end else if (bus.wb_valid && bus.wb_dest == rd_addr[p]) begin
                rd_valid[p] = 1'b1;
                rd_data[p]  = bus.wb_data;
            end else if (cnt_q[rd_addr[p]] == '0) begin
                rd_valid[p] = 1'b1;
                rd_data[p]  = rf_q[rd_addr[p]];
            end
        end
    end

    assign bus.r1_valid = rd_valid[0];
    assign bus.r1_data  = rd_data[0];
    assign bus.r2_valid = rd_valid[1];
    assign bus.r2_data  = rd_data[1];

    // Conservative: a same-cycle writeback does not release a saturated counter early.
    assign bus.issue_block = (bus.issue_dest != 5'd0) && (cnt_q[bus.issue_dest] == CntMax);

    a_no_issue_when_blocked : assert property (
        @(posedge clk) disable iff (!resetn)
        !(bus.issue_valid && bus.issue_block)
    );

    a_no_decrement_of_zero : assert property (
        @(posedge clk) disable iff (!resetn)
        !(!bus.flush && bus.wb_valid && bus.wb_dest != 5'd0
          && !issue_hit[bus.wb_dest] && cnt_q[bus.wb_dest] == '0)
    );

endmodule
